spi_ram_ctrl: RTL and testbench

//  Single-port RAM controller directly downstream of the SPI slave.

---
 rtl/spi_ram_if.sv | 28 ++
 rtl/spi_ram_ctrl.sv | 157 +++++++++++++++
 tb/tb_spi_ram_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_ram_if.sv
// Command/response bundle between the SPI slave and the RAM controller.
// The SPI slave side is the master (it issues commands); the controller is the slave.
interface spi_ram_if;
    logic [9:0] din;
    logic       rx_valid;
    logic [7:0] dout;
    logic       tx_valid;
    logic       err;
    logic [1:0] err_code;

    modport master (
        output din,
        output rx_valid,
        input  dout,
        input  tx_valid,
        input  err,
        input  err_code
    );

    modport slave (
        input  din,
        input  rx_valid,
        output dout,
        output tx_valid,
        output err,
        output err_code
    );
endinterface

// File: rtl/spi_ram_ctrl.sv
// Single-port RAM controller fed by 10-bit SPI command words.
// din[9:8] selects write-address / write-data / read-address / read-data.
// Read bytes are presented on dout with tx_valid held for TX_HOLD cycles so
// the SPI slave has time to shift the whole byte out on MISO.
module spi_ram_ctrl #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8,
    parameter int AUTO_INC  = 1,
    parameter int TX_HOLD   = 10
) (
    input  logic     clk,
    input  logic     rst_n,
    spi_ram_if.slave bus
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_DEPTH - 1);
    localparam logic [7:0]           HOLD_LAST = 8'(TX_HOLD - 1);

    logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
    logic                 rd_armed_q, rd_armed_d;
    logic [7:0]           hold_cnt_q, hold_cnt_d;
    logic [0:0]           state_q, state_d;
    logic                 tx_valid_q, tx_valid_d;
    logic                 err_q, err_d;
    logic [1:0]           err_code_q, err_code_d;
    logic [7:0]           dout_q;

    logic [7:0] mem [MEM_DEPTH];

    logic [1:0] op;
    logic [7:0] arg;
    logic       in_range;
    logic       wr_en;
    logic       rd_accept;

    assign op        = bus.din[9:8];
    assign arg       = bus.din[7:0];
    assign in_range  = ({24'd0, arg} < 32'(MEM_DEPTH));
    assign wr_en     = rst_n && bus.rx_valid && (op == OP_WR_DATA);
    assign rd_accept = bus.rx_valid && (op == OP_RD_DATA) && rd_armed_q;

    // Command decode, error flags and the tx_valid hold sequencer.
    always_comb begin
        wr_addr_d  = wr_addr_q;
        rd_addr_d  = rd_addr_q;
        rd_armed_d = rd_armed_q;
        hold_cnt_d = hold_cnt_q;
        state_d    = state_q;
        tx_valid_d = tx_valid_q;
        err_d      = 1'b0;
        err_code_d = 2'b00;

        if (bus.rx_valid) begin
            case (op)
                OP_WR_ADDR: begin
                    if (in_range) begin
                        wr_addr_d = arg[ADDR_SIZE-1:0];
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = 2'b10;
                    end
                end
                OP_WR_DATA: begin
                    if (AUTO_INC != 0) begin
                        wr_addr_d = (wr_addr_q == LAST_ADDR) ? '0 : wr_addr_q + 1'b1;
                    end
                end
                OP_RD_ADDR: begin
                    if (in_range) begin
                        rd_addr_d  = arg[ADDR_SIZE-1:0];
                        rd_armed_d = 1'b1;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = 2'b10;
                    end
                end
                default: begin
                    if (rd_armed_q) begin
                        rd_armed_d = 1'b0;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = 2'b01;
                    end
                end
            endcase
        end

        // A new accepted read always restarts the hold window.
        if (rd_accept) begin
            state_d    = HOLD;
            tx_valid_d = 1'b1;
            hold_cnt_d = 8'd0;
        end else if (state_q == HOLD) begin
            if (hold_cnt_q == HOLD_LAST) begin
                state_d    = IDLE;
                tx_valid_d = 1'b0;
                hold_cnt_d = 8'd0;
            end else begin
                hold_cnt_d = hold_cnt_q + 8'd1;
            end
        end
    end

    // Control state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            rd_armed_q <= 1'b0;
            hold_cnt_q <= 8'd0;
            state_q    <= IDLE;
            tx_valid_q <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
        end else begin
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            rd_armed_q <= rd_armed_d;
            hold_cnt_q <= hold_cnt_d;
            state_q    <= state_d;
            tx_valid_q <= tx_valid_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    // RAM write port; contents are deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr_q] <= arg;
        end
    end

    // Registered RAM read; dout keeps its value once the hold window ends.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout_q <= 8'd0;
        end else if (rd_accept) begin
            dout_q <= mem[rd_addr_q];
        end
    end

    assign bus.dout     = dout_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.err      = err_q;
    assign bus.err_code = err_code_q;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Testbench for spi_ram_ctrl: directed scenarios plus randomized commands
// compared against a behavioural model of the RAM controller.
module tb_spi_ram_ctrl;

    localparam int TX_HOLD = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_ram_if bus ();
    spi_ram_if bus_s ();

    spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(1), .TX_HOLD(TX_HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    spi_ram_ctrl #(.MEM_DEPTH(128), .ADDR_SIZE(7), .AUTO_INC(1), .TX_HOLD(3)) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_s)
    );

    int checks = 0;
    int failures = 0;

    // Reference model state for the 256-deep instance
    logic [7:0] m_mem [256];
    int         m_wr, m_rd;
    bit         m_armed;
    logic [7:0] m_dout;
    bit         m_err;
    logic [1:0] m_code;
    bit         m_tx;
    int         cyc = 0;
    int         last_rd = -1000;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_update(input logic rst, input logic v, input logic [9:0] cmd);
        int d;
        d = int'(cmd[7:0]);
        cyc++;
        m_err  = 1'b0;
        m_code = 2'b00;
        if (!rst) begin
            m_wr = 0; m_rd = 0; m_armed = 1'b0; m_dout = 8'd0; last_rd = -1000;
        end else if (v) begin
            case (cmd[9:8])
                2'b00: if (d < 256) m_wr = d; else begin m_err = 1; m_code = 2'b10; end
                2'b01: begin m_mem[m_wr] = cmd[7:0]; m_wr = (m_wr + 1) % 256; end
                2'b10: if (d < 256) begin m_rd = d; m_armed = 1; end
                       else begin m_err = 1; m_code = 2'b10; end
                default: begin
                    if (m_armed) begin
                        m_dout = m_mem[m_rd]; last_rd = cyc; m_armed = 0;
                    end else begin
                        m_err = 1; m_code = 2'b01;
                    end
                end
            endcase
        end
        m_tx = ((cyc - last_rd) < TX_HOLD);
    endtask

    // One clock of the main instance: drive, sample, compare to the model
    task automatic step(input logic rst, input logic v, input logic [9:0] cmd);
        rst_n = rst;
        bus.rx_valid = v;
        bus.din = cmd;
        @(posedge clk);
        model_update(rst, v, cmd);
        #1;
        check("dout", 32'(bus.dout), 32'(m_dout));
        check("tx_valid", 32'(bus.tx_valid), 32'(m_tx));
        check("err", 32'(bus.err), 32'(m_err));
        check("err_code", 32'(bus.err_code), 32'(m_code));
        if (v && rst)
            $display("cmd %03h -> dout=%02h tx_valid=%0b err=%0b err_code=%0d",
                     cmd, bus.dout, bus.tx_valid, bus.err, bus.err_code);
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    // One clock of the 128-deep instance with directed expectations
    task automatic step_s(input logic v, input logic [9:0] cmd, input logic [7:0] e_dout,
                          input logic e_tx, input logic e_err, input logic [1:0] e_code);
        rst_n = 1'b1;
        bus.rx_valid = 1'b0;
        bus_s.rx_valid = v;
        bus_s.din = cmd;
        @(posedge clk);
        model_update(1'b1, 1'b0, 10'd0);
        #1;
        check("s_dout", 32'(bus_s.dout), 32'(e_dout));
        check("s_tx_valid", 32'(bus_s.tx_valid), 32'(e_tx));
        check("s_err", 32'(bus_s.err), 32'(e_err));
        check("s_err_code", 32'(bus_s.err_code), 32'(e_code));
        $display("s cmd %03h v=%0b -> dout=%02h tx_valid=%0b err=%0b err_code=%0d",
                 cmd, v, bus_s.dout, bus_s.tx_valid, bus_s.err, bus_s.err_code);
        @(negedge clk);
        bus_s.rx_valid = 1'b0;
    endtask

    initial begin
        int high;
        bus.rx_valid = 1'b0;
        bus.din = 10'd0;
        bus_s.rx_valid = 1'b0;
        bus_s.din = 10'd0;

        // Reset for two cycles
        step(1'b0, 1'b0, 10'd0);
        step(1'b0, 1'b0, 10'd0);
        check("rst_dout", 32'(bus.dout), 32'h0);
        check("rst_tx_valid", 32'(bus.tx_valid), 32'h0);
        check("rst_err", 32'(bus.err), 32'h0);
        check("rst_err_code", 32'(bus.err_code), 32'h0);
        check("rst_s_tx_valid", 32'(bus_s.tx_valid), 32'h0);

        // Fill the whole RAM so every later read has known contents
        step(1'b1, 1'b1, 10'h000);
        for (int i = 0; i < 256; i++) step(1'b1, 1'b1, {2'b01, 8'($urandom_range(0, 255))});

        // Write/read with a full hold window
        step(1'b1, 1'b1, 10'h010);
        step(1'b1, 1'b1, 10'h1A5);
        step(1'b1, 1'b1, 10'h210);
        step(1'b1, 1'b1, 10'h300);
        check("wr_rd_dout", 32'(bus.dout), 32'hA5);
        check("wr_rd_tx", 32'(bus.tx_valid), 32'h1);
        for (int i = 0; i < TX_HOLD; i++) step(1'b1, 1'b0, 10'd0);
        check("hold_end_tx", 32'(bus.tx_valid), 32'h0);
        check("hold_end_dout", 32'(bus.dout), 32'hA5);

        // Unarmed read is rejected
        step(1'b1, 1'b1, 10'h300);
        check("unarmed_err", 32'(bus.err), 32'h1);
        check("unarmed_code", 32'(bus.err_code), 32'h1);
        check("unarmed_tx", 32'(bus.tx_valid), 32'h0);
        step(1'b1, 1'b0, 10'd0);
        check("err_pulse_clear", 32'(bus.err), 32'h0);

        // Auto-increment wraps from 0xFF to 0
        step(1'b1, 1'b1, 10'h0FF);
        step(1'b1, 1'b1, 10'h111);
        step(1'b1, 1'b1, 10'h122);
        step(1'b1, 1'b1, 10'h200);
        step(1'b1, 1'b1, 10'h300);
        check("wrap_dout0", 32'(bus.dout), 32'h22);
        step(1'b1, 1'b1, 10'h2FF);
        step(1'b1, 1'b1, 10'h300);
        check("wrap_doutff", 32'(bus.dout), 32'h11);
        for (int i = 0; i < TX_HOLD; i++) step(1'b1, 1'b0, 10'd0);

        // Hold restart: second read 3 cycles after the first
        step(1'b1, 1'b1, 10'h020);
        step(1'b1, 1'b1, 10'h133);
        step(1'b1, 1'b1, 10'h144);
        step(1'b1, 1'b1, 10'h220);
        step(1'b1, 1'b1, 10'h300);
        check("restart_doutA", 32'(bus.dout), 32'h33);
        step(1'b1, 1'b1, 10'h221);
        step(1'b1, 1'b0, 10'd0);
        step(1'b1, 1'b1, 10'h300);
        check("restart_doutB", 32'(bus.dout), 32'h44);
        high = 4;
        for (int i = 0; i < 20 && bus.tx_valid; i++) begin
            step(1'b1, 1'b0, 10'd0);
            if (bus.tx_valid) high++;
        end
        check("restart_hold_len", 32'(high), 32'd13);

        // Reset mid-hold drops tx_valid at that edge
        step(1'b1, 1'b1, 10'h220);
        step(1'b1, 1'b1, 10'h300);
        step(1'b1, 1'b0, 10'd0);
        step(1'b0, 1'b0, 10'd0);
        check("rst_mid_hold_tx", 32'(bus.tx_valid), 32'h0);
        check("rst_mid_hold_dout", 32'(bus.dout), 32'h0);
        step(1'b1, 1'b0, 10'd0);

        // 128-deep instance: range errors, unarmed read, wrap, short hold
        step_s(1'b1, 10'h280, 8'h00, 1'b0, 1'b1, 2'b10);
        step_s(1'b1, 10'h300, 8'h00, 1'b0, 1'b1, 2'b01);
        step_s(1'b1, 10'h080, 8'h00, 1'b0, 1'b1, 2'b10);
        step_s(1'b1, 10'h07F, 8'h00, 1'b0, 1'b0, 2'b00);
        step_s(1'b1, 10'h15A, 8'h00, 1'b0, 1'b0, 2'b00);
        step_s(1'b1, 10'h1C3, 8'h00, 1'b0, 1'b0, 2'b00);
        step_s(1'b1, 10'h27F, 8'h00, 1'b0, 1'b0, 2'b00);
        step_s(1'b1, 10'h300, 8'h5A, 1'b1, 1'b0, 2'b00);
        step_s(1'b1, 10'h200, 8'h5A, 1'b1, 1'b0, 2'b00);
        step_s(1'b1, 10'h300, 8'hC3, 1'b1, 1'b0, 2'b00);
        step_s(1'b0, 10'h000, 8'hC3, 1'b1, 1'b0, 2'b00);
        step_s(1'b0, 10'h000, 8'hC3, 1'b1, 1'b0, 2'b00);
        step_s(1'b0, 10'h000, 8'hC3, 1'b0, 1'b0, 2'b00);

        // Randomized commands with occasional resets
        for (int i = 0; i < 3000; i++) begin
            logic r;
            r = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            step(r, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)));
        end
        for (int i = 0; i < TX_HOLD + 2; i++) step(1'b1, 1'b0, 10'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
